reg_file_ckpt: RTL

Architectural register file with rename-tag table for the out-of-order core, parametrised in width, depth, tag size and checkpoint count. Decode reads operand value/tag and renames rd; ROB commit writes values and retires tags. Adds behaviour the flat table lacks:
- Commit-to-decode bypass.
- A bank of rename-table checkpoints, so a mispredicted branch restores the table in one cycle instead of flushing every tag.

---
 rtl/reg_file_ckpt_pkg.sv | 15 +
 rtl/reg_file_ckpt_if.sv | 52 +++++
 rtl/reg_file_ckpt_ckpt_alloc.sv | 20 ++
 rtl/reg_file_ckpt.sv | 126 ++++++++++++
 4 files changed

// File: rtl/reg_file_ckpt_pkg.sv
// Shared widths and constants for the register file with rename checkpoints.
// Every other file of this block imports this package.
package reg_file_ckpt_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int REG_NUM       = 32;
  localparam int REG_TAG_WIDTH = 5;
  localparam int ROB_TAG_WIDTH = 4;
  localparam int CKPT_NUM      = 4;
  localparam int CKPT_W        = 2;

  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_ROB_TAG = '0;
  localparam logic [CKPT_W-1:0]        ZERO_CKPT_ID = '0;
  localparam logic                     TRUE         = 1'b1;
  localparam logic                     FALSE        = 1'b0;
endpackage

// File: rtl/reg_file_ckpt_if.sv
// Decode, commit and checkpoint-control signals of the register file.
// Driven by the core (master) and consumed by reg_file_ckpt (slave).
interface reg_file_ckpt_if
  import reg_file_ckpt_pkg::*;
#(
  parameter int XLEN   = reg_file_ckpt_pkg::DATA_WIDTH,
  parameter int REG_W  = reg_file_ckpt_pkg::REG_TAG_WIDTH,
  parameter int ROB_W  = reg_file_ckpt_pkg::ROB_TAG_WIDTH,
  parameter int CKPT_W = reg_file_ckpt_pkg::CKPT_W
);
  // No handshake: every input is a one-cycle command sampled at posedge
  // when rdy=1; read outputs are combinational and always live.
  logic [REG_W-1:0]  in_decode_rs1;
  logic [REG_W-1:0]  in_decode_rs2;
  logic [REG_W-1:0]  in_decode_rd;
  logic [ROB_W-1:0]  in_decode_reorder;
  logic [ROB_W-1:0]  out_reg_rs1_reorder;
  logic [ROB_W-1:0]  out_reg_rs2_reorder;
  logic [XLEN-1:0]   out_reg_rs1_value;
  logic [XLEN-1:0]   out_reg_rs2_value;
  logic [REG_W-1:0]  in_rob_index;
  logic [XLEN-1:0]   in_rob_value;
  logic [ROB_W-1:0]  in_rob_reorder;
  logic              in_ckpt_take;
  logic [CKPT_W-1:0] out_ckpt_id;
  logic              out_ckpt_full;
  logic              in_ckpt_restore;
  logic [CKPT_W-1:0] in_ckpt_restore_id;
  logic              in_ckpt_free;
  logic [CKPT_W-1:0] in_ckpt_free_id;
  logic              in_reg_misbranch;

  modport master (
    output in_decode_rs1, in_decode_rs2, in_decode_rd, in_decode_reorder,
    output in_rob_index, in_rob_value, in_rob_reorder,
    output in_ckpt_take, in_ckpt_restore, in_ckpt_restore_id,
    output in_ckpt_free, in_ckpt_free_id, in_reg_misbranch,
    input  out_reg_rs1_reorder, out_reg_rs2_reorder,
    input  out_reg_rs1_value, out_reg_rs2_value,
    input  out_ckpt_id, out_ckpt_full
  );

  modport slave (
    input  in_decode_rs1, in_decode_rs2, in_decode_rd, in_decode_reorder,
    input  in_rob_index, in_rob_value, in_rob_reorder,
    input  in_ckpt_take, in_ckpt_restore, in_ckpt_restore_id,
    input  in_ckpt_free, in_ckpt_free_id, in_reg_misbranch,
    output out_reg_rs1_reorder, out_reg_rs2_reorder,
    output out_reg_rs1_value, out_reg_rs2_value,
    output out_ckpt_id, out_ckpt_full
  );
endinterface

// File: rtl/reg_file_ckpt_ckpt_alloc.sv
// Checkpoint slot allocator: lowest-index free slot and an all-busy flag.
// The id is 0 when every slot is busy; callers must gate with o_full.
module reg_file_ckpt_ckpt_alloc
  import reg_file_ckpt_pkg::*;
#(
  parameter int CKPT_NUM = reg_file_ckpt_pkg::CKPT_NUM,
  parameter int CKPT_W   = reg_file_ckpt_pkg::CKPT_W
) (
  input  logic [CKPT_NUM-1:0] i_valid,
  output logic [CKPT_W-1:0]   o_id,
  output logic                o_full
);
  always_comb begin
    o_id   = '0;
    o_full = &i_valid;
    for (int k = CKPT_NUM - 1; k >= 0; k--) begin
      if (!i_valid[k]) o_id = CKPT_W'(k);
    end
  end
endmodule

// File: rtl/reg_file_ckpt.sv
// Architectural register file plus rename-tag table with commit bypass and
// a bank of rename-table checkpoints for single-cycle branch recovery.
module reg_file_ckpt
  import reg_file_ckpt_pkg::*;
#(
  parameter int XLEN     = reg_file_ckpt_pkg::DATA_WIDTH,
  parameter int REG_NUM  = reg_file_ckpt_pkg::REG_NUM,
  parameter int REG_W    = reg_file_ckpt_pkg::REG_TAG_WIDTH,
  parameter int ROB_W    = reg_file_ckpt_pkg::ROB_TAG_WIDTH,
  parameter int CKPT_NUM = reg_file_ckpt_pkg::CKPT_NUM,
  parameter int CKPT_W   = reg_file_ckpt_pkg::CKPT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  reg_file_ckpt_if.slave bus
);
  logic [XLEN-1:0]     r_value    [REG_NUM];
  logic [ROB_W-1:0]    r_reorder  [REG_NUM];
  logic [ROB_W-1:0]    r_ckpt_tbl [CKPT_NUM][REG_NUM];
  logic [CKPT_NUM-1:0] r_ckpt_valid;

  logic [ROB_W-1:0]    w_live_clr [REG_NUM];
  logic [ROB_W-1:0]    w_ckpt_clr [CKPT_NUM][REG_NUM];
  logic                w_commit;
  logic                w_rename;
  logic                w_take;
  logic                w_bypass1;
  logic                w_bypass2;
  logic [CKPT_W-1:0]   w_ckpt_id;
  logic                w_ckpt_full;

  reg_file_ckpt_ckpt_alloc #(
    .CKPT_NUM (CKPT_NUM),
    .CKPT_W   (CKPT_W)
  ) u_alloc (
    .i_valid (r_ckpt_valid),
    .o_id    (w_ckpt_id),
    .o_full  (w_ckpt_full)
  );

  assign bus.out_ckpt_id   = w_ckpt_id;
  assign bus.out_ckpt_full = w_ckpt_full;

  // Commit clears a tag only when it still names the committing instruction,
  // so a younger rename of the same register survives.
  always_comb begin
    w_commit = (bus.in_rob_index != '0);
    w_rename = (bus.in_decode_rd != '0) && (bus.in_decode_reorder != ZERO_ROB_TAG);
    w_take   = bus.in_ckpt_take && !w_ckpt_full;
    for (int i = 0; i < REG_NUM; i++) begin
      w_live_clr[i] = r_reorder[i];
      if (w_commit && (bus.in_rob_index == REG_W'(i)) && (r_reorder[i] == bus.in_rob_reorder))
        w_live_clr[i] = ZERO_ROB_TAG;
      for (int k = 0; k < CKPT_NUM; k++) begin
        w_ckpt_clr[k][i] = r_ckpt_tbl[k][i];
        if (w_commit && (bus.in_rob_index == REG_W'(i)) && (r_ckpt_tbl[k][i] == bus.in_rob_reorder))
          w_ckpt_clr[k][i] = ZERO_ROB_TAG;
      end
    end
  end

  always_comb begin
    w_bypass1 = (bus.in_decode_rs1 != '0) && (bus.in_rob_index == bus.in_decode_rs1) &&
                (bus.in_rob_reorder == r_reorder[bus.in_decode_rs1]);
    w_bypass2 = (bus.in_decode_rs2 != '0) && (bus.in_rob_index == bus.in_decode_rs2) &&
                (bus.in_rob_reorder == r_reorder[bus.in_decode_rs2]);
    bus.out_reg_rs1_value   = r_value[bus.in_decode_rs1];
    bus.out_reg_rs1_reorder = r_reorder[bus.in_decode_rs1];
    bus.out_reg_rs2_value   = r_value[bus.in_decode_rs2];
    bus.out_reg_rs2_reorder = r_reorder[bus.in_decode_rs2];
    if (bus.in_decode_rs1 == '0) begin
      bus.out_reg_rs1_value   = '0;
      bus.out_reg_rs1_reorder = ZERO_ROB_TAG;
    end else if (w_bypass1) begin
      bus.out_reg_rs1_value   = bus.in_rob_value;
      bus.out_reg_rs1_reorder = ZERO_ROB_TAG;
    end
    if (bus.in_decode_rs2 == '0) begin
      bus.out_reg_rs2_value   = '0;
      bus.out_reg_rs2_reorder = ZERO_ROB_TAG;
    end else if (w_bypass2) begin
      bus.out_reg_rs2_value   = bus.in_rob_value;
      bus.out_reg_rs2_reorder = ZERO_ROB_TAG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i]   <= '0;
        r_reorder[i] <= ZERO_ROB_TAG;
        for (int k = 0; k < CKPT_NUM; k++) r_ckpt_tbl[k][i] <= ZERO_ROB_TAG;
      end
      r_ckpt_valid <= '0;
    end else if (rdy) begin
      if (bus.in_reg_misbranch) begin
        for (int i = 0; i < REG_NUM; i++) r_reorder[i] <= ZERO_ROB_TAG;
        r_ckpt_valid <= '0;
      end else begin
        if (w_commit) r_value[bus.in_rob_index] <= bus.in_rob_value;
        if (bus.in_ckpt_restore) begin
          for (int i = 0; i < REG_NUM; i++)
            r_reorder[i] <= w_ckpt_clr[bus.in_ckpt_restore_id][i];
          r_ckpt_valid <= '0;
        end else begin
          for (int i = 0; i < REG_NUM; i++) r_reorder[i] <= w_live_clr[i];
          if (w_rename) r_reorder[bus.in_decode_rd] <= bus.in_decode_reorder;
          for (int k = 0; k < CKPT_NUM; k++)
            for (int i = 0; i < REG_NUM; i++) r_ckpt_tbl[k][i] <= w_ckpt_clr[k][i];
          if (bus.in_ckpt_free) r_ckpt_valid[bus.in_ckpt_free_id] <= FALSE;
          // Snapshot excludes this cycle's rename: the branch's own rd is not rolled back to.
          if (w_take) begin
            for (int i = 0; i < REG_NUM; i++) r_ckpt_tbl[w_ckpt_id][i] <= w_live_clr[i];
            r_ckpt_valid[w_ckpt_id] <= TRUE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !bus.in_reg_misbranch && !bus.in_ckpt_restore && bus.in_ckpt_take)
      assert (!w_ckpt_full) else $warning("checkpoint take ignored: all slots in use");
  end
endmodule
